clause_assignment_scanner: RTL

CLAUSE_ASSIGNMENT_SCANNER -- requirements
Module: clause_assignment_scanner

---
 rtl/clause_assignment_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clause_assignment_scanner.sv
// clause_assignment_scanner
// Scans a packed bus of clauses (each clause an OR of literal bits) one
// clause per cycle from a snapshot taken at start. Reports whether every clause
// is satisfied, how many are not, and the lowest index of an unsatisfied clause.
//
// Ports:
//   clk               : clock, all logic on posedge
//   rst_n             : synchronous active-low reset
//   start             : scan request, honoured only in IDLE or DONE
//   clauses_in        : packed clause bus, clause k at [k*NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE]
//   busy              : high while scanning
//   done              : one-cycle pulse when results are published
//   sat               : all clauses satisfied
//   unsat_count       : number of unsatisfied clauses
//   first_unsat_valid : at least one clause unsatisfied
//   first_unsat_idx   : lowest unsatisfied clause index (0 when none)
module clause_assignment_scanner #(
    parameter int unsigned NUM_CLAUSES         = 16,
    parameter int unsigned NUM_VARS_PER_CLAUSE = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [NUM_CLAUSES*NUM_VARS_PER_CLAUSE-1:0]  clauses_in,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        sat,
    output logic [$clog2(NUM_CLAUSES+1)-1:0]            unsat_count,
    output logic                                        first_unsat_valid,
    output logic [((NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1)-1:0] first_unsat_idx
);

    localparam int unsigned BUS_W = NUM_CLAUSES * NUM_VARS_PER_CLAUSE;
    localparam int unsigned CNT_W = $clog2(NUM_CLAUSES + 1);
    localparam int unsigned IDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [BUS_W-1:0]               snap_q, snap_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [CNT_W-1:0]               acc_cnt_q, acc_cnt_d;
    logic [IDX_W-1:0]               acc_idx_q, acc_idx_d;
    logic                           acc_vld_q, acc_vld_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           sat_q, sat_d;
    logic [CNT_W-1:0]               unsat_count_q, unsat_count_d;
    logic                           first_unsat_valid_q, first_unsat_valid_d;
    logic [IDX_W-1:0]               first_unsat_idx_q, first_unsat_idx_d;

    logic [NUM_VARS_PER_CLAUSE-1:0] cur_clause;
    logic                           clause_unsat;
    logic [CNT_W-1:0]               cnt_next;
    logic [IDX_W-1:0]               idx_next;
    logic                           vld_next;

    // Clause currently addressed by the scan pointer (snapshot only).
    always_comb begin
        cur_clause = '0;
        for (int unsigned k = 0; k < NUM_CLAUSES; k++) begin
            if (ptr_q == IDX_W'(k)) begin
                cur_clause = snap_q[k*NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE];
            end
        end
    end

    // Accumulator values including the clause evaluated this cycle.
    always_comb begin
        clause_unsat = ~(|cur_clause);
        cnt_next     = acc_cnt_q + CNT_W'(clause_unsat);
        idx_next     = acc_idx_q;
        vld_next     = acc_vld_q;
        // Only the first unsatisfied clause records its index.
        if (clause_unsat && !acc_vld_q) begin
            idx_next = ptr_q;
            vld_next = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d             = state_q;
        snap_d              = snap_q;
        ptr_d               = ptr_q;
        acc_cnt_d           = acc_cnt_q;
        acc_idx_d           = acc_idx_q;
        acc_vld_d           = acc_vld_q;
        busy_d              = 1'b0;
        done_d              = 1'b0;
        sat_d               = sat_q;
        unsat_count_d       = unsat_count_q;
        first_unsat_valid_d = first_unsat_valid_q;
        first_unsat_idx_d   = first_unsat_idx_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    snap_d    = clauses_in;
                    ptr_d     = '0;
                    acc_cnt_d = '0;
                    acc_idx_d = '0;
                    acc_vld_d = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                acc_cnt_d = cnt_next;
                acc_idx_d = idx_next;
                acc_vld_d = vld_next;
                if (ptr_q == LAST_IDX) begin
                    // Last clause: publish all results together, pointer stays put.
                    state_d             = ST_DONE;
                    done_d              = 1'b1;
                    sat_d               = (cnt_next == '0);
                    unsat_count_d       = cnt_next;
                    first_unsat_valid_d = vld_next;
                    first_unsat_idx_d   = idx_next;
                end else begin
                    ptr_d  = ptr_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            snap_q              <= '0;
            ptr_q               <= '0;
            acc_cnt_q           <= '0;
            acc_idx_q           <= '0;
            acc_vld_q           <= 1'b0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            sat_q               <= 1'b0;
            unsat_count_q       <= '0;
            first_unsat_valid_q <= 1'b0;
            first_unsat_idx_q   <= '0;
        end else begin
            state_q             <= state_d;
            snap_q              <= snap_d;
            ptr_q               <= ptr_d;
            acc_cnt_q           <= acc_cnt_d;
            acc_idx_q           <= acc_idx_d;
            acc_vld_q           <= acc_vld_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
            sat_q               <= sat_d;
            unsat_count_q       <= unsat_count_d;
            first_unsat_valid_q <= first_unsat_valid_d;
            first_unsat_idx_q   <= first_unsat_idx_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign sat               = sat_q;
    assign unsat_count       = unsat_count_q;
    assign first_unsat_valid = first_unsat_valid_q;
    assign first_unsat_idx   = first_unsat_idx_q;

endmodule
